// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device transmitter. Sends one command byte per
//            request using the inhibit / request-to-send / device-clocked
//            frame, driving both PS/2 lines open-drain through output
//            enables, and reports ack or timeout per byte.
// Ports    : clk, resetn          - system clock, async active-low reset
//            tx_data/tx_valid/tx_ready - byte request handshake
//            ps2_clk_in/ps2_data_in   - raw (asynchronous) PS/2 lines
//            ps2_clk_oe/ps2_data_oe   - 1 = pull line low, 0 = release
//            busy, done, ack_ok, err  - status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_XFER      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              clk_s1_q, clk_sync_q, clk_prev_q;
  logic              data_s1_q, data_sync_q;
  logic              fall;
  logic [9:0]        frame_q, frame_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [INH_W-1:0]  inh_q, inh_d;
  logic [TMO_W-1:0]  tmr_q, tmr_d;
  logic              drive_q, drive_d;     // 1 = data line pulled low
  logic              ack_reg_q, ack_reg_d;
  logic              ack_ok_q, ack_ok_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              data_oe_w;

  // Two-flop synchronisers; the extra clock flop gives the falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s1_q    <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_s1_q   <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_s1_q    <= ps2_clk_in;
      clk_sync_q  <= clk_s1_q;
      clk_prev_q  <= clk_sync_q;
      data_s1_q   <= ps2_data_in;
      data_sync_q <= data_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bitcnt_q  <= '0;
      inh_q     <= '0;
      tmr_q     <= '0;
      drive_q   <= 1'b0;
      ack_reg_q <= 1'b0;
      ack_ok_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bitcnt_q  <= bitcnt_d;
      inh_q     <= inh_d;
      tmr_q     <= tmr_d;
      drive_q   <= drive_d;
      ack_reg_q <= ack_reg_d;
      ack_ok_q  <= ack_ok_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bitcnt_d  = bitcnt_q;
    inh_d     = inh_q;
    tmr_d     = tmr_q;
    drive_d   = drive_q;
    ack_reg_d = ack_reg_q;
    ack_ok_d  = ack_ok_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    data_oe_w = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          // Frame sent LSB first after the start bit: data, odd parity, stop.
          frame_d  = {1'b1, ~^tx_data, tx_data};
          bitcnt_d = '0;
          inh_d    = '0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          // Start bit goes out on the last inhibit cycle so data is already
          // low when the clock is released.
          data_oe_w = 1'b1;
          drive_d   = 1'b1;
          tmr_d     = '0;
          state_d   = S_RTS;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      S_RTS: begin
        data_oe_w = drive_q;
        if (fall) begin
          drive_d  = ~frame_q[0];
          frame_d  = {1'b1, frame_q[9:1]};
          bitcnt_d = 4'd1;
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        data_oe_w = drive_q;
        if (fall) begin
          if (bitcnt_q == 4'd10) begin
            ack_reg_d = ~data_sync_q;
            drive_d   = 1'b0;
            state_d   = S_ACK;
          end else begin
            drive_d  = ~frame_q[0];
            frame_d  = {1'b1, frame_q[9:1]};
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      S_ACK: begin
        state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          done_d   = 1'b1;
          ack_ok_d = ack_reg_q;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Timeout overrides everything once the clock has been released. The
    // compare is against TIMEOUT_CYCLES-1 so that err appears exactly
    // TIMEOUT_CYCLES cycles after release, with both lines let go.
    if (state_q == S_RTS || state_q == S_XFER ||
        state_q == S_ACK || state_q == S_WAIT_IDLE) begin
      tmr_d = tmr_q + 1'b1;
      if (tmr_q == TMO_LAST) begin
        state_d  = S_IDLE;
        err_d    = 1'b1;
        done_d   = 1'b0;
        drive_d  = 1'b0;
        ack_ok_d = ack_ok_q;
      end
    end
  end

  // Line enables decode straight from state so an async reset releases
  // both lines immediately.
  assign ps2_clk_oe  = (state_q == S_INHIBIT);
  assign ps2_data_oe = data_oe_w;
  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with an open-drain line
//            model and a behavioural PS/2 device that clocks at a 40-cycle
//            period, samples the host frame on rising edges and optionally
//            acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;

  localparam int INH = 10;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_ok, err;
  logic       dev_clk = 1'b1;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  int viol_cnt = 0;
  int exp_done = 0;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_line  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_line = ~ps2_data_oe & ~dev_data_low;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Running pulse counts and line-drive rules while idle.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) overlap_cnt <= overlap_cnt + 1;
    if (tx_ready && (ps2_clk_oe || ps2_data_oe)) viol_cnt <= viol_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Odd parity from a population count.
  function automatic logic odd_parity(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2 == 0);
  endfunction

  // Present a byte for one cycle at a negedge; returns one negedge later.
  task automatic issue(input logic [7:0] b);
    @(negedge clk);
    check("ready_before_issue", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Called at the first INHIBIT negedge; returns at the first RTS negedge.
  task automatic inhibit_phase();
    int n, nd;
    logic last_d;
    n = 0; nd = 0; last_d = 1'b0;
    while (ps2_clk_oe && n < 100) begin
      if (ps2_data_oe) nd++;
      last_d = ps2_data_oe;
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("start_on_last_inhibit_only", nd, 1);
    check("start_last_cycle", last_d, 1'b1);
    check("rts_clk_released", ps2_clk_oe, 1'b0);
    check("rts_data_low", ps2_data_oe, 1'b1);
  endtask

  // Device clocking; seen[0] is the start bit, seen[k+1] the bit read on
  // rising edge k. The 11th pulse returns right at its rising edge.
  task automatic dev_pulses(input int np, input bit ack, input bit scramble,
                            output logic [10:0] seen);
    seen = '1;
    seen[0] = ps2_data_line;
    for (int k = 0; k < np; k++) begin
      dev_clk = 1'b0;
      if (scramble) tx_data = 8'($urandom);
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      if (k == 10) begin
        dev_data_low = 1'b0;
        break;
      end
      seen[k+1] = ps2_data_line;
      repeat (10) @(negedge clk);
      if (k == 9 && ack) dev_data_low = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  // Full frame starting at the first INHIBIT negedge; ends one negedge
  // after done.
  task automatic run_frame(input logic [7:0] b, input bit ack, input bit scramble);
    logic [10:0] seen;
    bit got;
    inhibit_phase();
    repeat (10) @(negedge clk);
    dev_pulses(11, ack, scramble, seen);
    check("start_bit", seen[0], 1'b0);
    check("data_bits", seen[8:1], b);
    check("parity_bit", seen[9], odd_parity(b));
    check("stop_bit", seen[10], 1'b1);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    exp_done++;
    check("done_seen", got, 1'b1);
    check("ack_ok", ack_ok, ack);
    check("err_with_done", err, 1'b0);
    check("ready_at_done", tx_ready, 1'b1);
    check("lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    logic [7:0] b2;
    int n;
    int dsnap;
    bit ackr;
    logic [10:0] seen;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rst_done", done, 1'b0);
    check("rst_ack_ok", ack_ok, 1'b0);
    check("rst_err", err, 1'b0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Directed bytes
    issue(8'hED); run_frame(8'hED, 1'b1, 1'b0);
    issue(8'h00); run_frame(8'h00, 1'b1, 1'b0);
    issue(8'hFF); run_frame(8'hFF, 1'b0, 1'b0);

    // Device never clocks: timeout measured from clock release
    dsnap = done_cnt;
    issue(8'h3C);
    inhibit_phase();
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    check("timeout_latency", n, TMO);
    check("timeout_err", err, 1'b1);
    check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    check("err_one_cycle", err, 1'b0);
    check("timeout_no_done", done_cnt - dsnap, 0);
    issue(8'h5A); run_frame(8'h5A, 1'b1, 1'b0);

    // tx_valid held with tx_data changing during the frame
    @(negedge clk);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    run_frame(8'hA5, 1'b1, 1'b1);
    b2 = tx_data;
    tx_valid = 1'b0;
    run_frame(b2, 1'b1, 1'b0);

    // Reset in the middle of the transfer
    issue(8'h00);
    inhibit_phase();
    repeat (10) @(negedge clk);
    dev_pulses(5, 1'b0, 1'b0, seen);
    check("pre_reset_bits", seen[5:1], 5'b00000);
    dev_clk = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_data_low", ps2_data_oe, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("reset_clk_oe", ps2_clk_oe, 1'b0);
    check("reset_data_oe", ps2_data_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    dev_clk = 1'b1; dev_data_low = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    issue(8'hF4); run_frame(8'hF4, 1'b1, 1'b0);

    // Random bytes and random device acknowledge
    for (int r = 0; r < 6; r++) begin
      b2   = 8'($urandom);
      ackr = 1'($urandom_range(0, 1));
      issue(b2);
      run_frame(b2, ackr, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("total_done", done_cnt, exp_done);
    check("total_err", err_cnt, 1);
    check("done_err_overlap", overlap_cnt, 0);
    check("idle_line_drive", viol_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
